// File: rtl/pipe_hazard_sched_if.sv
// Pipeline-side bundle for the interlock scheduler.
// The master is the pipeline. It drives the step-2 instruction fields and the
// step-3 branch resolution. The slave is the scheduler. It returns the hazard,
// stall, bubble and flush controls, the FSM state and the stall counter.
//   opcode/rs/rt/rd_step_2, valid_step_2 : instruction currently in step 2
//   beq_taken_step_3                     : beq in step 3 resolved taken
//   is_hazzard, stall, bubble_step_3, flush : interlock controls for this cycle
//   state, stall_cnt                     : registered status
interface pipe_hazard_sched_if #(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned REG_W    = 5,
    parameter int unsigned CNT_W    = 16
);
    logic [OPCODE_W-1:0] opcode_step_2;
    logic [REG_W-1:0]    rs_step_2;
    logic [REG_W-1:0]    rt_step_2;
    logic [REG_W-1:0]    rd_step_2;
    logic                valid_step_2;
    logic                beq_taken_step_3;
    logic                is_hazzard;
    logic                stall;
    logic                bubble_step_3;
    logic                flush;
    logic [1:0]          state;
    logic [CNT_W-1:0]    stall_cnt;

    modport master (
        output opcode_step_2, rs_step_2, rt_step_2, rd_step_2, valid_step_2,
               beq_taken_step_3,
        input  is_hazzard, stall, bubble_step_3, flush, state, stall_cnt
    );

    modport slave (
        input  opcode_step_2, rs_step_2, rt_step_2, rd_step_2, valid_step_2,
               beq_taken_step_3,
        output is_hazzard, stall, bubble_step_3, flush, state, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_sched.sv
// Interlock scheduler for a 5-step pipeline.
// It tracks the destination registers in flight in steps 3..5. It stalls steps
// 1-2 on a read-after-write dependency and flushes steps 1-2 on a taken beq.
// In both cases it places a bubble into step 3.
//   clk, rst : pipeline clock and synchronous active-high reset
//   bus      : slave side of pipe_hazard_sched_if
//              (step-2 instruction in, interlock controls and status out)
// is_hazzard, stall, flush and bubble_step_3 are combinational decisions for the
// current cycle. state and stall_cnt are registered.
module pipe_hazard_sched #(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned REG_W    = 5,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    pipe_hazard_sched_if.slave  bus
);
    localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
    localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             v3_q, v4_q, v5_q;
    logic [REG_W-1:0] d3_q, d4_q, d5_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic             writes_c, use_rs_c, use_rt_c, hazard_c;
    logic [REG_W-1:0] dst_c;
    logic             stall_c, flush_c, bubble_c, issue_c;

    // A non-zero source is a hazard while any valid tracker entry targets it.
    // T5 still counts because the register file writes on the step-5 edge.
    function automatic logic hit(input logic [REG_W-1:0] src,
                                 input logic v3, input logic [REG_W-1:0] d3,
                                 input logic v4, input logic [REG_W-1:0] d4,
                                 input logic v5, input logic [REG_W-1:0] d5);
        hit = (src != '0) && ((v3 && d3 == src) || (v4 && d4 == src) ||
                              (v5 && d5 == src));
    endfunction

    // Step-2 decode: the written register and the sources actually read.
    always_comb begin
        writes_c = 1'b0;
        dst_c    = '0;
        use_rs_c = 1'b0;
        use_rt_c = 1'b0;
        case (bus.opcode_step_2)
            OP_RTYPE: begin
                writes_c = 1'b1;
                dst_c    = bus.rd_step_2;
                use_rs_c = 1'b1;
                use_rt_c = 1'b1;
            end
            OP_ADDI, OP_LW: begin
                writes_c = 1'b1;
                dst_c    = bus.rt_step_2;
                use_rs_c = 1'b1;
            end
            OP_SW, OP_BEQ: begin
                use_rs_c = 1'b1;
                use_rt_c = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        hazard_c = bus.valid_step_2 &&
                   ((use_rs_c && hit(bus.rs_step_2, v3_q, d3_q, v4_q, d4_q, v5_q, d5_q)) ||
                    (use_rt_c && hit(bus.rt_step_2, v3_q, d3_q, v4_q, d4_q, v5_q, d5_q)));
    end

    // Next-state and interlock decision; a taken beq overrides a pending stall.
    always_comb begin
        stall_c  = 1'b0;
        flush_c  = 1'b0;
        bubble_c = 1'b0;
        issue_c  = 1'b0;
        state_d  = ST_RUN;
        if (bus.beq_taken_step_3) begin
            flush_c  = 1'b1;
            bubble_c = 1'b1;
            state_d  = ST_FLUSH;
        end else if (hazard_c) begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
            state_d  = ST_STALL;
        end else begin
            issue_c  = bus.valid_step_2;
        end
    end

    // State register, destination tracker shift and saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            v3_q        <= 1'b0;
            v4_q        <= 1'b0;
            v5_q        <= 1'b0;
            d3_q        <= '0;
            d4_q        <= '0;
            d5_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            v5_q    <= v4_q;
            d5_q    <= d4_q;
            v4_q    <= v3_q;
            d4_q    <= d3_q;
            v3_q    <= issue_c && writes_c && (dst_c != '0);
            d3_q    <= dst_c;
            if (stall_c && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.is_hazzard    = hazard_c;
    assign bus.stall         = stall_c;
    assign bus.flush         = flush_c;
    assign bus.bubble_step_3 = bubble_c;
    assign bus.state         = state_q;
    assign bus.stall_cnt     = stall_cnt_q;
endmodule
